// File: rtl/ls191_ctrl_pkg.sv
// rtl/ls191_ctrl_pkg.sv - shared state and encoding constants for the LS191 sweep controller
package ls191_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, COUNT, DONE} state_t;

  localparam logic MODE_RELOAD   = 1'b0;
  localparam logic MODE_PINGPONG = 1'b1;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/sweep_shadow_cnt.sv
// rtl/sweep_shadow_cnt.sv - shadow copy of the external counter chain with mismatch compare
module sweep_shadow_cnt
  import ls191_ctrl_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_en,
  input  logic [CNT_W-1:0] load_val,
  input  logic             cnt_en,
  input  logic             dir,
  input  logic [CNT_W-1:0] count_in,
  output logic [CNT_W-1:0] value,
  output logic             mismatch
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (load_en) begin
      value <= load_val;
    end else if (cnt_en) begin
      value <= (dir == DIR_DOWN) ? value - CNT_W'(1) : value + CNT_W'(1);
    end
  end

  assign mismatch = (count_in != value);

endmodule

// File: rtl/ls191_sweep_ctrl.sv
// rtl/ls191_sweep_ctrl.sv - drives an LS191-style counter chain through N preset->terminal sweeps
module ls191_sweep_ctrl
  import ls191_ctrl_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int SWEEPS_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic                mode,
  input  logic                start_dir,
  input  logic [CNT_W-1:0]    preset,
  input  logic [SWEEPS_W-1:0] sweeps,
  input  logic                max_min,
  input  logic [CNT_W-1:0]    count_in,
  output logic                load,
  output logic [CNT_W-1:0]    d_out,
  output logic                cten,
  output logic                du,
  output logic                busy,
  output logic                done,
  output logic                err
);

  state_t              state;
  logic [CNT_W-1:0]    preset_q;
  logic [SWEEPS_W-1:0] left;
  logic                mode_q;
  logic                dir;
  logic                in_count;
  logic                shadow_mm;
  logic [CNT_W-1:0]    shadow;

  assign in_count = (state == COUNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      preset_q <= '0;
      left     <= '0;
      mode_q   <= MODE_RELOAD;
      dir      <= DIR_UP;
      err      <= 1'b0;
    end else begin
      if (in_count && shadow_mm) begin
        err <= 1'b1;
      end
      if (abort) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              preset_q <= preset;
              left     <= sweeps;
              mode_q   <= mode;
              dir      <= start_dir;
              err      <= 1'b0;
              state    <= (sweeps == '0) ? DONE : LOAD;
            end
          end
          LOAD: state <= COUNT;
          COUNT: begin
            if (max_min) begin
              left <= left - SWEEPS_W'(1);
              if (left == SWEEPS_W'(1)) begin
                state <= DONE;
              end else if (mode_q == MODE_RELOAD) begin
                state <= LOAD;
              end else begin
                dir <= ~dir;
              end
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  sweep_shadow_cnt #(.CNT_W(CNT_W)) u_shadow (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_en  (state == LOAD),
    .load_val (preset_q),
    .cnt_en   (in_count && !max_min),
    .dir      (dir),
    .count_in (count_in),
    .value    (shadow),
    .mismatch (shadow_mm)
  );

  // Direction comes only from the register so max_min never loops back through du.
  assign du    = dir;
  assign d_out = preset_q;
  assign load  = (state != LOAD);
  assign cten  = in_count ? max_min : 1'b1;
  assign busy  = (state == LOAD) || (state == COUNT);
  assign done  = (state == DONE);

endmodule

// File: tb/tb_ls191_sweep_ctrl.sv
// tb/tb_ls191_sweep_ctrl.sv - bench for ls191_sweep_ctrl with a behavioural 4-bit counter chain
module tb_ls191_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, start, abort, mode, start_dir;
  logic [3:0] preset, sweeps;
  logic       max_min;
  logic [3:0] count_in;
  logic       load, cten, du, busy, done, err;
  logic [3:0] d_out;
  logic [3:0] q_model = 4'd0;
  logic [3:0] bump = 4'd0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int load_q[$];
  int done_q[$];
  logic [5:0] cnt_q[$];

  always #5 clk = ~clk;

  ls191_sweep_ctrl #(.CNT_W(4), .SWEEPS_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
    .start_dir(start_dir), .preset(preset), .sweeps(sweeps), .max_min(max_min),
    .count_in(count_in), .load(load), .d_out(d_out), .cten(cten), .du(du),
    .busy(busy), .done(done), .err(err)
  );

  // Counter chain: synchronous load, counts while cten is low.
  assign max_min  = du ? (q_model == 4'd0) : (q_model == 4'hF);
  assign count_in = q_model + bump;
  always @(posedge clk) begin
    if (!load) q_model <= d_out;
    else if (!cten) q_model <= du ? q_model - 4'd1 : q_model + 4'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected count-phase sample: {cten, du, q}; cten must equal the terminal flag.
  task automatic push_cnt(input int q, input logic d);
    logic [3:0] qq;
    logic term;
    qq = q[3:0];
    term = d ? (qq == 4'd0) : (qq == 4'hF);
    cnt_q.push_back({term, d, qq});
  endtask

  always @(negedge clk) begin
    if (!load) begin
      if (load_q.size() == 0) chk("load_unexpected", cyc, -1);
      else chk("load_cyc", cyc, load_q.pop_front());
    end
    if (done) begin
      if (done_q.size() == 0) chk("done_unexpected", cyc, -1);
      else chk("done_cyc", cyc, done_q.pop_front());
    end
    if (busy && load && cnt_q.size() > 0) chk("count_phase", {cten, du, q_model}, cnt_q.pop_front());
    cyc++;
  end

  task automatic start_run(input logic [3:0] p, input logic d, input logic [3:0] sw, input logic m);
    @(posedge clk); #1;
    preset = p; start_dir = d; sweeps = sw; mode = m; start = 1'b1;
    cyc = 0;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic end_run(input string tag);
    chk({tag, "_loads_left"}, load_q.size(), 0);
    chk({tag, "_dones_left"}, done_q.size(), 0);
    chk({tag, "_counts_left"}, cnt_q.size(), 0);
    chk({tag, "_err"}, err, 0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_load"}, load, 1);
    chk({tag, "_cten"}, cten, 1);
    chk({tag, "_du"}, du, 0);
    chk({tag, "_d_out"}, d_out, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 1'b0; start_dir = 1'b0;
    preset = 4'd0; sweeps = 4'd0;
    #2;
    chk_reset_outs("reset");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // 1: single up sweep from D
    load_q.push_back(1); done_q.push_back(5);
    for (int q = 13; q <= 15; q++) push_cnt(q, 1'b0);
    start_run(4'hD, 1'b0, 4'd1, 1'b0);
    repeat (7) @(negedge clk);
    end_run("t1");

    // 2: ping-pong from E, two terminal hits
    load_q.push_back(1); done_q.push_back(20);
    for (int q = 14; q <= 15; q++) push_cnt(q, 1'b0);
    for (int q = 15; q >= 0; q--) push_cnt(q, 1'b1);
    start_run(4'hE, 1'b0, 4'd2, 1'b1);
    repeat (22) @(negedge clk);
    end_run("t2");

    // 3: reload mode down from 2, three sweeps
    load_q.push_back(1); load_q.push_back(5); load_q.push_back(9); done_q.push_back(13);
    for (int s = 0; s < 3; s++) for (int q = 2; q >= 0; q--) push_cnt(q, 1'b1);
    start_run(4'h2, 1'b1, 4'd3, 1'b0);
    repeat (15) @(negedge clk);
    end_run("t3");

    // 4: zero sweeps completes without loading
    done_q.push_back(1);
    start_run(4'h5, 1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t4_busy", busy, 0);
    end
    end_run("t4");

    // 5: one corrupted count sample sets sticky err
    load_q.push_back(1); done_q.push_back(15);
    start_run(4'h3, 1'b0, 4'd1, 1'b0);
    @(posedge clk); @(posedge clk); @(posedge clk); #1;
    bump = 4'd1;
    @(posedge clk); #1;
    bump = 4'd0;
    @(negedge clk);
    chk("t5_err_set", err, 1);
    repeat (11) @(negedge clk);
    chk("t5_err_sticky", err, 1);
    chk("t5_dones_left", done_q.size(), 0);
    load_q.push_back(1); done_q.push_back(5);
    for (int q = 13; q <= 15; q++) push_cnt(q, 1'b0);
    start_run(4'hD, 1'b0, 4'd1, 1'b0);
    @(negedge clk);
    chk("t5_err_cleared", err, 0);
    repeat (6) @(negedge clk);
    end_run("t5b");

    // 6a: abort coinciding with a terminal hit
    load_q.push_back(1);
    push_cnt(14, 1'b0); push_cnt(15, 1'b0);
    start_run(4'hE, 1'b0, 4'd2, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("t6_busy", busy, 0);
    chk("t6_cten", cten, 1);
    chk("t6_done", done, 0);
    chk("t6_load", load, 1);
    repeat (6) @(negedge clk);
    end_run("t6");

    // 6b: reset in the middle of a down count
    load_q.push_back(1);
    for (int q = 9; q >= 7; q--) push_cnt(q, 1'b1);
    start_run(4'h9, 1'b1, 4'd1, 1'b0);
    @(posedge clk); @(posedge clk); @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    chk_reset_outs("t6_rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_rst_hold", q_model, 6);
    end_run("t6_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
